// File: rtl/seven_seg_controller_if.sv
// Producer-side handshake into the seven-segment front end.
// The producer holds in_valid and the payload until it sees in_ready.
interface seven_seg_controller_if #(
  parameter int unsigned BIN_WIDTH = 27
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIN_WIDTH-1:0] in_value;
  logic                 in_hex;
  logic                 blank_zeros;

  modport master (
    output in_valid,
    output in_value,
    output in_hex,
    output blank_zeros,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_value,
    input  in_hex,
    input  blank_zeros,
    output in_ready
  );
endinterface

// File: rtl/seven_seg_controller.sv
// Front end for the 8-digit seven-segment driver: binary-to-BCD conversion,
// leading-zero blanking and the per-digit refresh strobe.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a value; in_ready high
// CONVERT  | one double-dabble iteration per cycle, BIN_WIDTH cycles
// COMMIT   | publish digits / anodes_mask / overflow in one edge
module seven_seg_controller #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BIN_WIDTH   = 27
) (
  input  logic                   clk,
  input  logic                   rst,
  seven_seg_controller_if.slave  bus,
  output logic                   ce,
  output logic [31:0]            digits,
  output logic [7:0]             anodes_mask,
  output logic                   busy,
  output logic                   overflow
);

  localparam int unsigned PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned ITER_W = $clog2(BIN_WIDTH + 1);
  localparam int unsigned EXT_W  = BIN_WIDTH + 32;
  localparam logic [EXT_W-1:0] DEC_MAX = EXT_W'(99_999_999);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_COMMIT
  } state_t;

  state_t               state_q, state_d;
  logic [PRE_W-1:0]     pre_cnt;
  logic                 pre_tc;
  logic [31:0]          bcd_q;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [ITER_W-1:0]    iter_q;
  logic                 ovf_pend_q;
  logic                 blank_q;

  logic                 accept;
  logic [EXT_W-1:0]     value_ext;
  logic                 too_big;
  logic [31:0]          bcd_adj;
  logic [31:0]          bcd_nxt;
  logic [BIN_WIDTH-1:0] bin_nxt;
  logic [7:0]           mask_calc;
  logic                 seen;

  // Refresh prescaler runs regardless of the FSM so refresh timing never jitters.
  assign pre_tc = (pre_cnt == PRE_W'(REFRESH_DIV - 1));
  assign ce     = pre_tc && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (pre_tc) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign bus.in_ready = (state_q == S_IDLE) && !rst;
  assign busy         = (state_q != S_IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign value_ext    = {32'd0, bus.in_value};
  assign too_big      = (value_ext > DEC_MAX);

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign {bcd_nxt, bin_nxt} = {bcd_adj[30:0], bin_q, 1'b0};

  // Bit i is lit when digit i or any more significant digit is nonzero.
  always_comb begin
    seen      = 1'b0;
    mask_calc = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      seen         = seen | (bcd_q[4*i +: 4] != 4'd0);
      mask_calc[i] = seen;
    end
    mask_calc[0] = 1'b1;
    if (!blank_q) begin
      mask_calc = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.in_hex || too_big) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_CONVERT;
          end
        end
      end
      S_CONVERT: begin
        if (iter_q == ITER_W'(BIN_WIDTH - 1)) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q       <= '0;
      bin_q       <= '0;
      iter_q      <= '0;
      ovf_pend_q  <= 1'b0;
      blank_q     <= 1'b0;
      digits      <= 32'h0;
      anodes_mask <= 8'h01;
      overflow    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            blank_q    <= bus.blank_zeros;
            bin_q      <= bus.in_value;
            iter_q     <= '0;
            ovf_pend_q <= !bus.in_hex && too_big;
            bcd_q      <= bus.in_hex ? value_ext[31:0] : 32'h0;
          end
        end
        S_CONVERT: begin
          bcd_q  <= bcd_nxt;
          bin_q  <= bin_nxt;
          iter_q <= iter_q + 1'b1;
        end
        S_COMMIT: begin
          if (ovf_pend_q) begin
            digits      <= 32'hEEEE_EEEE;
            anodes_mask <= 8'hFF;
            overflow    <= 1'b1;
          end else begin
            digits      <= bcd_q;
            anodes_mask <= mask_calc;
            overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_controller.sv
// Directed bench for seven_seg_controller: table of conversions plus
// hand-written sequences for busy-time input, mid-conversion reset and ce timing.
module tb_seven_seg_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce, ce1;
  logic [31:0] digits, digits1;
  logic [7:0]  anodes_mask, anodes_mask1;
  logic        busy, busy1;
  logic        overflow, overflow1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] prev_digits = 32'h0;
  logic [7:0]  prev_mask   = 8'h01;
  logic        prev_ovf    = 1'b0;

  seven_seg_controller_if #(.BIN_WIDTH(27)) bus ();
  seven_seg_controller_if #(.BIN_WIDTH(27)) bus1 ();

  seven_seg_controller #(.REFRESH_DIV(4), .BIN_WIDTH(27)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ce(ce), .digits(digits),
    .anodes_mask(anodes_mask), .busy(busy), .overflow(overflow)
  );

  seven_seg_controller #(.REFRESH_DIV(1), .BIN_WIDTH(27)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .ce(ce1), .digits(digits1),
    .anodes_mask(anodes_mask1), .busy(busy1), .overflow(overflow1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] value;
    logic        hex;
    logic        blank;
    logic [31:0] exp_digits;
    logic [7:0]  exp_mask;
    logic        exp_ovf;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ce timing checked every cycle, so conversions running alongside are covered.
  always @(negedge clk) begin
    if (rst) begin
      chk("ce_in_reset", 32'(ce), 32'd0);
      chk("ce1_in_reset", 32'(ce1), 32'd0);
      cyc = 0;
    end else begin
      chk("ce_div4", 32'(ce), 32'((cyc % 4) == 3));
      chk("ce_div1", 32'(ce1), 32'd1);
      cyc++;
    end
  end

  task automatic send(input logic [26:0] v, input logic hx, input logic bl);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed %b, expected 1", bus.in_ready);
    end
    bus.in_valid    = 1'b1;
    bus.in_value    = v;
    bus.in_hex      = hx;
    bus.blank_zeros = bl;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Entered just after the accept edge; checks outputs hold until the commit edge.
  task automatic finish_txn(input string name, input logic [31:0] ed, input logic [7:0] em,
                            input logic eo, input int lat);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    chk({name, "_hold0"}, digits, prev_digits);
    repeat (lat - 1) @(posedge clk);
    #1;
    if (lat > 1) begin
      chk({name, "_hold_last"}, digits, prev_digits);
      chk({name, "_hold_mask"}, 32'(anodes_mask), 32'(prev_mask));
      chk({name, "_ready_low"}, 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    chk({name, "_digits"}, digits, ed);
    chk({name, "_mask"}, 32'(anodes_mask), 32'(em));
    chk({name, "_ovf"}, 32'(overflow), 32'(eo));
    chk({name, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    chk({name, "_idle"}, 32'(busy), 32'd0);
    prev_digits = ed;
    prev_mask   = em;
    prev_ovf    = eo;
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_value     = '0;
    bus.in_hex       = 1'b0;
    bus.blank_zeros  = 1'b0;
    bus1.in_valid    = 1'b0;
    bus1.in_value    = '0;
    bus1.in_hex      = 1'b0;
    bus1.blank_zeros = 1'b0;

    vecs[0]  = '{27'd12345678,  1'b0, 1'b1, 32'h12345678, 8'hFF, 1'b0, 28};
    vecs[1]  = '{27'd42,        1'b0, 1'b1, 32'h00000042, 8'h03, 1'b0, 28};
    vecs[2]  = '{27'd0,         1'b0, 1'b1, 32'h00000000, 8'h01, 1'b0, 28};
    vecs[3]  = '{27'd0,         1'b0, 1'b0, 32'h00000000, 8'hFF, 1'b0, 28};
    vecs[4]  = '{27'd100000000, 1'b0, 1'b1, 32'hEEEEEEEE, 8'hFF, 1'b1, 1};
    vecs[5]  = '{27'd7,         1'b0, 1'b1, 32'h00000007, 8'h01, 1'b0, 28};
    vecs[6]  = '{27'h0ABCDEF,   1'b1, 1'b1, 32'h00ABCDEF, 8'h3F, 1'b0, 1};
    vecs[7]  = '{27'd99999999,  1'b0, 1'b0, 32'h99999999, 8'hFF, 1'b0, 28};
    vecs[8]  = '{27'd100,       1'b0, 1'b1, 32'h00000100, 8'h07, 1'b0, 28};
    vecs[9]  = '{27'h7FFFFFF,   1'b1, 1'b1, 32'h07FFFFFF, 8'h7F, 1'b0, 1};
    vecs[10] = '{27'd1000,      1'b0, 1'b1, 32'h00001000, 8'h0F, 1'b0, 28};
    vecs[11] = '{27'h0000000,   1'b1, 1'b0, 32'h00000000, 8'hFF, 1'b0, 1};
    vecs[12] = '{27'd10000000,  1'b0, 1'b1, 32'h10000000, 8'hFF, 1'b0, 28};
    vecs[13] = '{27'd99999999,  1'b0, 1'b1, 32'h99999999, 8'hFF, 1'b0, 28};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_digits", digits, 32'h0);
    chk("rst_mask", 32'(anodes_mask), 32'h01);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      send(vecs[i].value, vecs[i].hex, vecs[i].blank);
      finish_txn($sformatf("vec%0d", i), vecs[i].exp_digits, vecs[i].exp_mask,
                 vecs[i].exp_ovf, vecs[i].lat);
    end

    // Producer wiggles in_valid while a decimal conversion is in flight.
    send(27'd31415926, 1'b0, 1'b1);
    chk("busyin_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.in_valid = k[0];
      bus.in_value = 27'd5 + 27'(k);
      bus.in_hex   = 1'b1;
      #1;
      chk("busyin_ready", 32'(bus.in_ready), 32'd0);
      chk("busyin_digits", digits, prev_digits);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_hex   = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("busyin_hold", digits, prev_digits);
    @(posedge clk);
    #1;
    chk("busyin_digits_new", digits, 32'h31415926);
    chk("busyin_mask_new", 32'(anodes_mask), 32'hFF);
    chk("busyin_ready_back", 32'(bus.in_ready), 32'd1);
    prev_digits = 32'h31415926;
    prev_mask   = 8'hFF;
    prev_ovf    = 1'b0;

    // Reset lands at iteration 10 of a conversion; nothing partial may surface.
    send(27'd99999999, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    chk("midrst_hold", digits, prev_digits);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_digits", digits, 32'h0);
    chk("midrst_mask", 32'(anodes_mask), 32'h01);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_back", 32'(bus.in_ready), 32'd1);
    prev_digits = 32'h0;
    prev_mask   = 8'h01;
    prev_ovf    = 1'b0;
    send(27'd5, 1'b0, 1'b1);
    finish_txn("after_rst", 32'h00000005, 8'h01, 1'b0, 28);

    repeat (10) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_controller.md
Name: seven_seg_controller

Overview:
Front-end controller for the 8-digit seven-segment display driver. It accepts a binary result through a valid/ready handshake. In decimal mode it converts the result to packed BCD with a sequential double-dabble engine; in hex mode it passes the value through. It computes the leading-zero blanking mask and drives the driver's digits, anodes_mask and ce inputs, including the refresh-rate prescaler.

Parameters:
REFRESH_DIV, 100000, clk cycles per ce pulse (per-digit refresh period); legal range 1..2^24.
BIN_WIDTH, 27, width of in_value; 27 is the minimum that covers 99_999_999.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
in_valid  input  1  producer has a value on in_value
in_ready  output  1  controller can accept; high only in IDLE and not in reset
in_value  input  BIN_WIDTH  unsigned binary value to display
in_hex  input  1  1 = show in_value[31:0] zero-extended as hex; 0 = decimal
blank_zeros  input  1  1 = suppress leading zero digits
ce  output  1  one-cycle refresh strobe to the display driver
digits  output  32  eight packed nibbles; digit 0 is bits [3:0]
anodes_mask  output  8  per-digit enable to the driver
busy  output  1  high in CONVERT and COMMIT
overflow  output  1  last committed decimal value exceeded 99_999_999

Behaviour:
- Reset values (while rst is high, and at the first edge after it):
  - state = IDLE; prescaler = 0; ce = 0.
  - digits = 32'h0; anodes_mask = 8'h01; overflow = 0; busy = 0.
  - in_ready is forced to 0 while rst is high.
- Handshake:
  - A transfer occurs on a rising edge where in_valid and in_ready are both high.
  - in_value, in_hex and blank_zeros are captured only at that edge.
  - in_valid outside IDLE is ignored; the producer must hold it.
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE, on transfer:
  - hex mode → COMMIT.
  - decimal mode with in_value > 99_999_999 → COMMIT with an overflow flag.
  - otherwise: clear the BCD accumulator, load the shift register, set iter = 0, go to CONVERT.
- CONVERT:
  - One double-dabble iteration per cycle: each BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1.
  - iter increments each cycle; after the BIN_WIDTH-th iteration → COMMIT.
- COMMIT: registers digits, anodes_mask and overflow in a single edge → IDLE.
- Latency, counted from the accept edge T:
  - decimal: outputs update at edge T+BIN_WIDTH+1 (T+28 at default); in_ready is high again in the cycle after that edge.
  - hex / overflow: outputs update at edge T+1.
- Overflow commit: digits = 32'hEEEEEEEE, anodes_mask = 8'hFF, overflow = 1. Any non-overflow commit clears overflow.
- Blanking mask:
  - If the captured blank_zeros = 0: anodes_mask = 8'hFF.
  - Else bit i = 1 iff i == 0 or some digit j >= i is nonzero. Digit 0 is always shown, so value 0 displays "0".
- digits and anodes_mask change only in COMMIT. They are glitch-free and stable between commits; intermediate BCD never reaches the outputs.
- Prescaler:
  - Free-running counter 0..REFRESH_DIV-1, independent of the FSM.
  - ce = 1 for exactly one cycle when the counter is at REFRESH_DIV-1; the counter wraps to 0 on that edge.
  - REFRESH_DIV = 1 → ce is high every cycle after reset.
- Reset mid-operation: abandons the conversion, outputs return to reset values, and no partial value is ever committed.
- A simultaneous ce pulse and COMMIT is legal; the driver may latch either the old or the new digit for that one refresh slot.

Test Plan:
- Decimal 12345678, blank_zeros=1 → digits 32'h12345678, anodes_mask 8'hFF, overflow 0, update exactly 28 cycles after accept.
- Decimal 42, blank_zeros=1 → digits 32'h00000042, anodes_mask 8'h03. Then 0 with blank_zeros=1 → digits 0, mask 8'h01. Then 0 with blank_zeros=0 → mask 8'hFF.
- Decimal 100000000 (27'h5F5E100) → digits 32'hEEEEEEEE, mask 8'hFF, overflow 1, update 1 cycle after accept. Next value 7 → overflow 0, digits 32'h7.
- Hex 27'h0ABCDEF, blank_zeros=1 → digits 32'h00ABCDEF, mask 8'h3F, 1-cycle latency. Toggling in_valid/in_value during a decimal CONVERT is not accepted (in_ready = 0) and digits stay unchanged.
- REFRESH_DIV=4 → ce high on cycles 3, 7, 11 … after reset release; REFRESH_DIV=1 → ce constantly 1. Prescaler timing is unaffected by conversions.
- Assert rst at iteration 10 of converting 99999999 → outputs at reset values the next cycle; in_ready high the cycle after rst deasserts; the following conversion of 5 gives 32'h5 with mask 8'h01 (blank_zeros=1).
